// File: rtl/tl_a_arbiter_pkg.sv
// Shared TileLink-UL/UH channel types, opcodes and beat helpers for the A-channel arbiter.
package tl_a_arbiter_pkg;

    localparam int NUM_MST    = 2;
    localparam int MST_W      = 1;
    localparam int SRC_W      = 4;
    localparam int DATA_BYTES = 8;
    localparam int DATA_LG    = $clog2(DATA_BYTES);
    localparam int TL_SRC_W   = MST_W + SRC_W;
    localparam int TL_DATA_W  = DATA_BYTES * 8;
    localparam int BEAT_W     = 16;

    localparam logic [2:0] TL_OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_OP_ARITH       = 3'd2;
    localparam logic [2:0] TL_OP_LOGIC       = 3'd3;
    localparam logic [2:0] TL_OP_GET         = 3'd4;
    localparam logic [2:0] TL_OP_INTENT      = 3'd5;
    localparam logic [2:0] TL_OP_ACK         = 3'd0;
    localparam logic [2:0] TL_OP_ACK_DATA    = 3'd1;

    // Upstream payloads use the same struct; only source[SRC_W-1:0] is meaningful there.
    typedef struct packed {
        logic [2:0]            opcode;
        logic [2:0]            param;
        logic [3:0]            size;
        logic [TL_SRC_W-1:0]   source;
        logic [31:0]           address;
        logic [DATA_BYTES-1:0] mask;
        logic [TL_DATA_W-1:0]  data;
        logic                  corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           param;
        logic [3:0]           size;
        logic [TL_SRC_W-1:0]  source;
        logic                 sink;
        logic                 denied;
        logic [TL_DATA_W-1:0] data;
        logic                 corrupt;
    } tl_d_t;

    function automatic logic tl_has_data(input logic [2:0] opcode);
        return (opcode == TL_OP_PUT_FULL) || (opcode == TL_OP_PUT_PARTIAL) ||
               (opcode == TL_OP_ARITH)    || (opcode == TL_OP_LOGIC);
    endfunction

    function automatic logic [BEAT_W-1:0] tl_beats(input logic [3:0] size);
        logic [BEAT_W-1:0] beats;
        if (size > 4'(DATA_LG)) begin
            beats = BEAT_W'(1) << (size - 4'(DATA_LG));
        end else begin
            beats = BEAT_W'(1);
        end
        return beats;
    endfunction

    function automatic logic [MST_W-1:0] rr_next(input logic [MST_W-1:0] idx);
        return (idx == MST_W'(NUM_MST - 1)) ? '0 : idx + MST_W'(1);
    endfunction

endpackage

// File: rtl/tl_a_arbiter_chk.sv
// Protocol checks for the arbiter: burst owner must hold valid, D tags must name a real master.
module tl_a_arbiter_chk
    import tl_a_arbiter_pkg::*;
(
    input logic               i_clk,
    input logic               i_rst,
    input logic               i_lock,
    input logic [MST_W-1:0]   i_gnt,
    input logic [NUM_MST-1:0] i_a_valid,
    input logic               i_d_valid,
    input logic               i_d_sel_ok
);

    a_burst_valid_held: assert property (@(posedge i_clk) disable iff (i_rst)
        i_lock |-> i_a_valid[i_gnt]);

    a_d_tag_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        i_d_valid |-> i_d_sel_ok);

endmodule

// File: rtl/tl_a_arbiter_rr_arb.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module tl_rr_arb #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic [N-1:0] w_gnt;
    logic [W-1:0] w_idx;
    logic [W-1:0] w_k;
    logic         w_any;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        w_any = 1'b0;
        w_k   = '0;
        for (int i = 0; i < N; i++) begin
            w_k = W'((int'(i_ptr) + i) % N);
            if (!w_any && i_req[w_k]) begin
                w_any        = 1'b1;
                w_gnt[w_k]   = 1'b1;
                w_idx        = w_k;
            end else begin
                w_any = w_any;
            end
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;
    assign o_any = w_any;

endmodule

// File: rtl/tl_a_arbiter.sv
// Round-robin A-channel arbiter with burst lock and source tagging; D channel demuxed by tag.
module tl_a_arbiter
    import tl_a_arbiter_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_MST-1:0]   m_a_valid_i,
    output logic [NUM_MST-1:0]   m_a_ready_o,
    input  tl_a_t [NUM_MST-1:0]  m_a_bits_i,
    output logic [NUM_MST-1:0]   m_d_valid_o,
    input  logic [NUM_MST-1:0]   m_d_ready_i,
    output tl_d_t                m_d_bits_o,
    output logic                 s_a_valid_o,
    input  logic                 s_a_ready_i,
    output tl_a_t                s_a_bits_o,
    input  logic                 s_d_valid_i,
    output logic                 s_d_ready_o,
    input  tl_d_t                s_d_bits_i
);

    logic                r_lock;
    logic [MST_W-1:0]    r_gnt;
    logic [MST_W-1:0]    r_rr_ptr;
    logic [BEAT_W-1:0]   r_beat_cnt;

    logic [NUM_MST-1:0]  w_arb_gnt;
    logic [MST_W-1:0]    w_arb_idx;
    logic                w_arb_any;
    logic [NUM_MST-1:0]  w_win_gnt;
    logic [MST_W-1:0]    w_win_idx;
    logic                w_win_vld;
    tl_a_t               w_win_bits;
    logic                w_a_fire;
    logic [BEAT_W-1:0]   w_beats;
    logic                w_multi;
    logic [MST_W-1:0]    w_d_sel;
    logic                w_d_sel_ok;
    logic                w_d_ready;

    tl_rr_arb #(.N(NUM_MST), .W(MST_W)) u_arb (
        .i_req (m_a_valid_i),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // A mux: the burst owner bypasses the arbiter until its last beat fires.
    always_comb begin
        w_win_idx  = r_lock ? r_gnt : w_arb_idx;
        w_win_vld  = r_lock ? m_a_valid_i[r_gnt] : w_arb_any;
        w_win_gnt  = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            w_win_gnt[i] = r_lock ? (r_gnt == MST_W'(i)) : w_arb_gnt[i];
        end
        w_win_bits = m_a_bits_i[w_win_idx];
        s_a_valid_o = w_win_vld & ~rst_i;
        m_a_ready_o = w_win_gnt & {NUM_MST{s_a_ready_i & w_win_vld & ~rst_i}};
        s_a_bits_o        = w_win_bits;
        s_a_bits_o.source = {w_win_idx, w_win_bits.source[SRC_W-1:0]};
        w_a_fire = s_a_valid_o & s_a_ready_i;
        w_beats  = tl_beats(w_win_bits.size);
        w_multi  = tl_has_data(w_win_bits.opcode) && (w_beats > BEAT_W'(1));
    end

    // Lock, owner, beat count and fairness pointer advance only on A fires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock     <= 1'b0;
            r_gnt      <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (w_a_fire) begin
            if (r_lock) begin
                r_beat_cnt <= r_beat_cnt - BEAT_W'(1);
                if (r_beat_cnt == BEAT_W'(1)) begin
                    r_lock   <= 1'b0;
                    r_rr_ptr <= rr_next(r_gnt);
                end else begin
                    r_lock   <= 1'b1;
                end
            end else if (w_multi) begin
                r_lock     <= 1'b1;
                r_gnt      <= w_win_idx;
                r_beat_cnt <= w_beats - BEAT_W'(1);
            end else begin
                r_rr_ptr   <= rr_next(w_win_idx);
            end
        end else begin
            r_lock <= r_lock;
        end
    end

    // D demux: stateless; an unknown tag is sunk so the slave never stalls on it.
    always_comb begin
        w_d_sel     = s_d_bits_i.source[TL_SRC_W-1:SRC_W];
        w_d_sel_ok  = 1'b0;
        w_d_ready   = 1'b1;
        m_d_valid_o = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (w_d_sel == MST_W'(i)) begin
                w_d_sel_ok     = 1'b1;
                w_d_ready      = m_d_ready_i[i];
                m_d_valid_o[i] = s_d_valid_i & ~rst_i;
            end else begin
                m_d_valid_o[i] = 1'b0;
            end
        end
        s_d_ready_o       = w_d_ready & ~rst_i;
        m_d_bits_o        = s_d_bits_i;
        m_d_bits_o.source = {{MST_W{1'b0}}, s_d_bits_i.source[SRC_W-1:0]};
    end

    tl_a_arbiter_chk u_chk (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_lock     (r_lock),
        .i_gnt      (r_gnt),
        .i_a_valid  (m_a_valid_i),
        .i_d_valid  (s_d_valid_i),
        .i_d_sel_ok (w_d_sel_ok)
    );

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Scoreboard bench for tl_a_arbiter: directed A/D traffic plus a saturated alternating run.
module tb_tl_a_arbiter;
    import tl_a_arbiter_pkg::*;

    typedef struct { logic [2:0] op; logic [3:0] size; logic [3:0] src; logic [63:0] data; } beat_t;
    typedef struct { int mst; logic [2:0] op; logic [3:0] size; logic [3:0] src; logic [63:0] data; } exp_a_t;
    typedef struct { logic [1:0] vld; logic [4:0] src; logic [63:0] data; logic rdy; } exp_d_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_a_valid, m_a_ready, m_d_valid, m_d_ready;
    tl_a_t [1:0] m_a_bits;
    tl_d_t       m_d_bits, s_d_bits;
    tl_a_t       s_a_bits;
    logic        s_a_valid, s_a_ready, s_d_valid, s_d_ready;

    beat_t  mq0[$];
    beat_t  mq1[$];
    exp_a_t exp_a[$];
    exp_d_t exp_d[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     fire_cnt[2];
    int     ready_mode = 0;

    always #5 clk = ~clk;

    tl_a_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m_a_valid_i (m_a_valid),
        .m_a_ready_o (m_a_ready),
        .m_a_bits_i  (m_a_bits),
        .m_d_valid_o (m_d_valid),
        .m_d_ready_i (m_d_ready),
        .m_d_bits_o  (m_d_bits),
        .s_a_valid_o (s_a_valid),
        .s_a_ready_i (s_a_ready),
        .s_a_bits_o  (s_a_bits),
        .s_d_valid_i (s_d_valid),
        .s_d_ready_o (s_d_ready),
        .s_d_bits_i  (s_d_bits)
    );

    function automatic int n_beats(input logic [2:0] op, input logic [3:0] size);
        if (op == TL_OP_GET || size <= 4'd3) return 1;
        return 1 << (int'(size) - 3);
    endfunction

    // Upper source bit is set to 1 on purpose: the arbiter must overwrite it with the master tag.
    function automatic tl_a_t mk_a(input beat_t b);
        tl_a_t a;
        a         = '0;
        a.opcode  = b.op;
        a.size    = b.size;
        a.source  = {1'b1, b.src};
        a.address = 32'h8000_0000 + 32'(b.data[7:0]);
        a.mask    = '1;
        a.data    = b.data;
        return a;
    endfunction

    task automatic issue(input int m, input logic [2:0] op, input logic [3:0] size,
                         input logic [3:0] src, input logic [63:0] data);
        for (int b = 0; b < n_beats(op, size); b++) begin
            beat_t bt;
            bt = '{op, size, src, data + 64'(b)};
            if (m == 0) mq0.push_back(bt);
            else        mq1.push_back(bt);
        end
    endtask

    task automatic expect_msg(input int m, input logic [2:0] op, input logic [3:0] size,
                              input logic [3:0] src, input logic [63:0] data);
        for (int b = 0; b < n_beats(op, size); b++) begin
            exp_a.push_back('{m, op, size, src, data + 64'(b)});
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((exp_a.size() != 0 || mq0.size() != 0 || mq1.size() != 0) && n < max) begin
            @(posedge clk);
            n++;
        end
        if (n >= max) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_a.size());
        end
        #2;
    endtask

    task automatic d_step(input logic [4:0] src, input logic [63:0] data, input logic [1:0] mrdy,
                          input logic [1:0] evld, input logic erdy);
        @(posedge clk);
        #1;
        s_d_valid     = 1'b1;
        s_d_bits      = '0;
        s_d_bits.opcode = TL_OP_ACK_DATA;
        s_d_bits.size = 4'd3;
        s_d_bits.source = src;
        s_d_bits.data = data;
        m_d_ready     = mrdy;
        exp_d.push_back('{evld, {1'b0, src[3:0]}, data, erdy});
    endtask

    // Stalled response to M1 (M0 ready, M1 not), then released, then a response to M0.
    task automatic d_test();
        for (int i = 0; i < 3; i++) d_step({1'b1, 4'h3}, 64'hD1D1, 2'b01, 2'b10, 1'b0);
        d_step({1'b1, 4'h3}, 64'hD1D1, 2'b10, 2'b10, 1'b1);
        d_step({1'b0, 4'h9}, 64'hD2D2, 2'b01, 2'b01, 1'b1);
        @(posedge clk);
        #1;
        s_d_valid = 1'b0;
        m_d_ready = 2'b00;
    endtask

    // Master drivers: pop a beat after it fired, then present the next head.
    initial begin : drv
        bit f0, f1;
        m_a_valid = 2'b00;
        m_a_bits  = '0;
        s_a_ready = 1'b0;
        fire_cnt[0] = 0;
        fire_cnt[1] = 0;
        forever begin
            @(negedge clk);
            f0 = m_a_valid[0] & m_a_ready[0];
            f1 = m_a_valid[1] & m_a_ready[1];
            @(posedge clk);
            #1;
            if (f0 && mq0.size() > 0) begin mq0.delete(0); fire_cnt[0]++; end
            if (f1 && mq1.size() > 0) begin mq1.delete(0); fire_cnt[1]++; end
            m_a_valid[0] = (mq0.size() > 0);
            m_a_valid[1] = (mq1.size() > 0);
            if (mq0.size() > 0) m_a_bits[0] = mk_a(mq0[0]);
            if (mq1.size() > 0) m_a_bits[1] = mk_a(mq1[0]);
            case (ready_mode)
                0:       s_a_ready = 1'b1;
                1:       s_a_ready = ~s_a_ready;
                2:       s_a_ready = ($urandom_range(3) != 0);
                default: s_a_ready = 1'b0;
            endcase
        end
    end

    // Downstream A monitor: every fire must match the next expected beat.
    initial begin : mon_a
        exp_a_t e;
        logic [1:0] er;
        forever begin
            @(negedge clk);
            if (s_a_valid && s_a_ready) begin
                n_cmp++;
                if (exp_a.size() == 0) begin
                    n_err++;
                    $display("FAIL a_unexpected: got src=%h data=%h, required no beat", s_a_bits.source, s_a_bits.data);
                end else begin
                    e  = exp_a.pop_front();
                    er = (e.mst == 0) ? 2'b01 : 2'b10;
                    if (s_a_bits.source !== {e.mst[0], e.src} || s_a_bits.data !== e.data ||
                        s_a_bits.opcode !== e.op || s_a_bits.size !== e.size || m_a_ready !== er) begin
                        n_err++;
                        $display("FAIL a_beat: got src=%h op=%0d size=%0d data=%h rdy=%b, required src=%h op=%0d size=%0d data=%h rdy=%b",
                                 s_a_bits.source, s_a_bits.opcode, s_a_bits.size, s_a_bits.data, m_a_ready,
                                 {e.mst[0], e.src}, e.op, e.size, e.data, er);
                    end
                end
            end
        end
    end

    // Upstream D monitor: every presented response must match the next expected one.
    initial begin : mon_d
        exp_d_t e;
        forever begin
            @(negedge clk);
            if (m_d_valid != 2'b00) begin
                n_cmp++;
                if (exp_d.size() == 0) begin
                    n_err++;
                    $display("FAIL d_unexpected: got vld=%b src=%h, required none", m_d_valid, m_d_bits.source);
                end else begin
                    e = exp_d.pop_front();
                    if (m_d_valid !== e.vld || m_d_bits.source !== e.src ||
                        m_d_bits.data !== e.data || s_d_ready !== e.rdy) begin
                        n_err++;
                        $display("FAIL d_beat: got vld=%b src=%h data=%h rdy=%b, required vld=%b src=%h data=%h rdy=%b",
                                 m_d_valid, m_d_bits.source, m_d_bits.data, s_d_ready,
                                 e.vld, e.src, e.data, e.rdy);
                    end
                end
            end
        end
    end

    initial begin : main
        int start;
        int n;
        logic [2:0] op0, op1;
        logic [3:0] sz0, sz1;
        rst       = 1'b1;
        m_d_ready = 2'b00;
        s_d_valid = 1'b0;
        s_d_bits  = '0;

        // Reset: outputs low even with every input asserted.
        @(posedge clk);
        #2;
        m_a_valid = 2'b11;
        s_d_valid = 1'b1;
        s_d_bits.source = {1'b1, 4'h3};
        m_d_ready = 2'b11;
        #1;
        chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
        chk("rst_m_a_ready", 64'(m_a_ready), 64'd0);
        chk("rst_m_d_valid", 64'(m_d_valid), 64'd0);
        chk("rst_s_d_ready", 64'(s_d_ready), 64'd0);
        s_d_valid = 1'b0;
        m_d_ready = 2'b00;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Simultaneous Gets: M0 then M1.
        issue(0, TL_OP_GET, 4'd3, 4'h5, 64'h1000);
        issue(1, TL_OP_GET, 4'd3, 4'hA, 64'h2000);
        expect_msg(0, TL_OP_GET, 4'd3, 4'h5, 64'h1000);
        expect_msg(1, TL_OP_GET, 4'd3, 4'hA, 64'h2000);
        wait_drain(200);

        // Move the pointer to M1, then a 4-beat M1 burst locks out a waiting M0.
        issue(0, TL_OP_GET, 4'd3, 4'h1, 64'h3000);
        expect_msg(0, TL_OP_GET, 4'd3, 4'h1, 64'h3000);
        wait_drain(200);
        issue(1, TL_OP_PUT_FULL, 4'd5, 4'h2, 64'h4000);
        issue(0, TL_OP_GET, 4'd3, 4'h3, 64'h5000);
        expect_msg(1, TL_OP_PUT_FULL, 4'd5, 4'h2, 64'h4000);
        expect_msg(0, TL_OP_GET, 4'd3, 4'h3, 64'h5000);
        wait_drain(200);

        // Same burst with toggling downstream ready, while D traffic runs alongside.
        ready_mode = 1;
        issue(1, TL_OP_PUT_FULL, 4'd5, 4'h4, 64'h6000);
        issue(0, TL_OP_GET, 4'd3, 4'h6, 64'h7000);
        expect_msg(1, TL_OP_PUT_FULL, 4'd5, 4'h4, 64'h6000);
        expect_msg(0, TL_OP_GET, 4'd3, 4'h6, 64'h7000);
        fork
            d_test();
            wait_drain(400);
        join
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #2;

        // Reset during beat 2 of an M1 burst; afterwards M0 must win first.
        issue(0, TL_OP_GET, 4'd3, 4'h7, 64'h8000);
        expect_msg(0, TL_OP_GET, 4'd3, 4'h7, 64'h8000);
        wait_drain(200);
        issue(1, TL_OP_PUT_FULL, 4'd5, 4'h8, 64'h9000);
        issue(0, TL_OP_GET, 4'd3, 4'hB, 64'hC000);
        exp_a.push_back('{1, TL_OP_PUT_FULL, 4'd5, 4'h8, 64'h9000});
        start = fire_cnt[1];
        n = 0;
        while (fire_cnt[1] == start && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("burst_first_beat_fired", 64'(fire_cnt[1] - start), 64'd1);
        rst = 1'b1;
        #1;
        chk("midburst_rst_s_a_valid", 64'(s_a_valid), 64'd0);
        chk("midburst_rst_m_a_ready", 64'(m_a_ready), 64'd0);
        mq0.delete();
        mq1.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        issue(0, TL_OP_GET, 4'd3, 4'h9, 64'hA000);
        issue(1, TL_OP_GET, 4'd3, 4'hA, 64'hB000);
        expect_msg(0, TL_OP_GET, 4'd3, 4'h9, 64'hA000);
        expect_msg(1, TL_OP_GET, 4'd3, 4'hA, 64'hB000);
        wait_drain(200);

        // Both masters saturated with mixed sizes and random backpressure: strict alternation.
        ready_mode = 2;
        for (int k = 0; k < 500; k++) begin
            case ($urandom_range(3))
                0:       begin op0 = TL_OP_GET;         sz0 = 4'd3; end
                1:       begin op0 = TL_OP_PUT_FULL;    sz0 = 4'd4; end
                2:       begin op0 = TL_OP_PUT_FULL;    sz0 = 4'd5; end
                default: begin op0 = TL_OP_PUT_PARTIAL; sz0 = 4'd3; end
            endcase
            case ($urandom_range(3))
                0:       begin op1 = TL_OP_PUT_FULL;    sz1 = 4'd5; end
                1:       begin op1 = TL_OP_GET;         sz1 = 4'd3; end
                2:       begin op1 = TL_OP_PUT_FULL;    sz1 = 4'd4; end
                default: begin op1 = TL_OP_PUT_PARTIAL; sz1 = 4'd3; end
            endcase
            issue(0, op0, sz0, 4'(k), 64'h00A0_0000_0000_0000 | (64'(k) << 8));
            issue(1, op1, sz1, 4'(k + 7), 64'h00B1_0000_0000_0000 | (64'(k) << 8));
            expect_msg(0, op0, sz0, 4'(k), 64'h00A0_0000_0000_0000 | (64'(k) << 8));
            expect_msg(1, op1, sz1, 4'(k + 7), 64'h00B1_0000_0000_0000 | (64'(k) << 8));
        end
        wait_drain(20000);
        ready_mode = 0;
        repeat (4) @(posedge clk);

        chk("a_leftover", 64'(exp_a.size()), 64'd0);
        chk("d_leftover", 64'(exp_d.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
